// File: rtl/arch_dump_pkg.sv
// Shared types for the architectural state dump path: FSM states, widths and the beat format.
package arch_dump_pkg;

  localparam int AREG_W = 5;
  localparam int PREG_W = 7;
  localparam int XLEN   = 32;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_Q,
    MAP,
    PRF,
    SEND
  } dump_state_t;

  typedef struct packed {
    logic [AREG_W-1:0] areg;
    logic [PREG_W-1:0] preg;
    logic [XLEN-1:0]   data;
  } dump_beat_t;

endpackage

// File: rtl/dump_out_stage.sv
// Single-entry output register for a debug beat stream; holds its beat until the consumer takes it.
module dump_out_stage
  import arch_dump_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  dump_beat_t load_beat,
  input  logic       load_last,
  input  logic       clear,
  input  logic       ready,
  output logic       valid,
  output dump_beat_t beat,
  output logic       last
);

  // clear beats load so a killed stream never emits a stale beat
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      beat  <= '0;
      last  <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      beat  <= load_beat;
      last  <= load_last;
    end else if (valid && ready) begin
      valid <= 1'b0;
      last  <= 1'b0;
    end
  end

endmodule

// File: rtl/arch_state_dump_unit.sv
// Walks the rename map and PRF and streams {areg, preg, value} beats for every architectural register.
// Define ARCH_DUMP_SKIP_X0_EN to start the walk at x1 and never read x0.
module arch_state_dump_unit
  import arch_dump_pkg::*;
#(
  parameter int NUM_AREGS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dump_req,
  input  logic              quiesced,
  input  logic              flush,
  output logic [AREG_W-1:0] map_rd_addr,
  input  logic [PREG_W-1:0] map_rd_preg,
  output logic              prf_rd_en,
  output logic [PREG_W-1:0] prf_rd_addr,
  input  logic [XLEN-1:0]   prf_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [AREG_W-1:0] out_areg,
  output logic [PREG_W-1:0] out_preg,
  output logic [XLEN-1:0]   out_data,
  output logic              out_last,
  output logic              dump_busy,
  output logic              dump_done,
  output logic              dump_abort
);

  localparam logic [AREG_W-1:0] LAST_AREG = AREG_W'(NUM_AREGS - 1);
`ifdef ARCH_DUMP_SKIP_X0_EN
  localparam logic [AREG_W-1:0] FIRST_AREG = AREG_W'(1);
`else
  localparam logic [AREG_W-1:0] FIRST_AREG = '0;
`endif

  dump_state_t       state;
  logic [AREG_W-1:0] idx;
  logic [PREG_W-1:0] preg_q;
  logic              stage_load;
  logic              stage_clear;
  logic              stage_valid;
  logic              stage_last;
  logic              handshake;
  dump_beat_t        stage_in;
  dump_beat_t        stage_beat;

  // x0 is architecturally zero, whatever its mapped PRF entry holds
  assign stage_in    = {idx, preg_q, (idx == '0) ? {XLEN{1'b0}} : prf_rd_data};
  assign stage_load  = (state == PRF) && !flush;
  assign stage_clear = flush && (state != IDLE);
  assign handshake   = stage_valid && out_ready;

  assign map_rd_addr = (state == MAP) ? idx : '0;
  assign prf_rd_en   = (state == MAP);
  assign prf_rd_addr = (state == MAP) ? map_rd_preg : '0;
  assign dump_busy   = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= '0;
      preg_q     <= '0;
      dump_done  <= 1'b0;
      dump_abort <= 1'b0;
    end else begin
      dump_done  <= 1'b0;
      dump_abort <= 1'b0;
      if (flush && state != IDLE) begin
        state      <= IDLE;
        dump_abort <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (dump_req && !flush) begin
              state <= WAIT_Q;
              idx   <= FIRST_AREG;
            end
          end
          WAIT_Q: begin
            if (quiesced) state <= MAP;
          end
          MAP: begin
            preg_q <= map_rd_preg;
            state  <= PRF;
          end
          PRF: begin
            state <= SEND;
          end
          SEND: begin
            if (handshake) begin
              if (idx == LAST_AREG) begin
                dump_done <= 1'b1;
                state     <= IDLE;
              end else begin
                idx   <= idx + AREG_W'(1);
                state <= MAP;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  dump_out_stage u_out_stage (
    .clk       (clk),
    .reset     (reset),
    .load      (stage_load),
    .load_beat (stage_in),
    .load_last (idx == LAST_AREG),
    .clear     (stage_clear),
    .ready     (out_ready),
    .valid     (stage_valid),
    .beat      (stage_beat),
    .last      (stage_last)
  );

  assign out_valid = stage_valid;
  assign out_areg  = stage_beat.areg;
  assign out_preg  = stage_beat.preg;
  assign out_data  = stage_beat.data;
  assign out_last  = stage_last;

endmodule

// File: tb/tb_arch_state_dump_unit.sv
// Randomized bench for arch_state_dump_unit: a map/PRF model feeds the DUT, a monitor logs beats.
module tb_arch_state_dump_unit;

  localparam int NREG = 32;
`ifdef ARCH_DUMP_SKIP_X0_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif
  localparam int NBEATS = NREG - FIRST;

  typedef struct packed {
    logic [4:0]  areg;
    logic [6:0]  preg;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        dump_req = 1'b0;
  logic        quiesced = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [4:0]  map_rd_addr;
  logic [6:0]  map_rd_preg;
  logic        prf_rd_en;
  logic [6:0]  prf_rd_addr;
  logic [31:0] prf_rd_data = '0;
  logic        out_valid;
  logic [4:0]  out_areg;
  logic [6:0]  out_preg;
  logic [31:0] out_data;
  logic        out_last;
  logic        dump_busy;
  logic        dump_done;
  logic        dump_abort;

  logic [6:0]  map_tbl [NREG];
  logic [31:0] prf_mem [128];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int hold_viol = 0;
  int abort_cnt = 0;
  beat_t got[$];
  beat_t exp_q[$];
  int read_cycs[$];
  int read_addrs[$];
  int done_cycs[$];
  beat_t cur;
  beat_t prev_beat;
  bit prev_hold = 0;

  arch_state_dump_unit dut (
    .clk         (clk),
    .reset       (reset),
    .dump_req    (dump_req),
    .quiesced    (quiesced),
    .flush       (flush),
    .map_rd_addr (map_rd_addr),
    .map_rd_preg (map_rd_preg),
    .prf_rd_en   (prf_rd_en),
    .prf_rd_addr (prf_rd_addr),
    .prf_rd_data (prf_rd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_areg    (out_areg),
    .out_preg    (out_preg),
    .out_data    (out_data),
    .out_last    (out_last),
    .dump_busy   (dump_busy),
    .dump_done   (dump_done),
    .dump_abort  (dump_abort)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign map_rd_preg = map_tbl[map_rd_addr];
  always @(posedge clk) if (prf_rd_en) prf_rd_data <= prf_mem[prf_rd_addr];

  assign cur = {out_areg, out_preg, out_data, out_last};

  // monitor samples mid-cycle and only appends, so tests work from baselines
  always @(negedge clk) begin
    if (reset) begin
      if (prf_rd_en) begin
        read_cycs.push_back(cyc);
        read_addrs.push_back(int'(map_rd_addr));
      end
      if (dump_done) done_cycs.push_back(cyc);
      if (dump_abort) abort_cnt++;
      if (prev_hold && !(out_valid && cur === prev_beat)) hold_viol++;
      if (out_valid && out_ready) got.push_back(cur);
      prev_hold = out_valid && !out_ready && !flush;
      prev_beat = cur;
    end else begin
      prev_hold = 0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task automatic randomize_state();
    for (int i = 0; i < 128; i++) prf_mem[i] = $urandom;
    for (int i = 0; i < NREG; i++) map_tbl[i] = 7'($urandom_range(0, 127));
  endtask

  task automatic build_expected();
    exp_q.delete();
    for (int a = FIRST; a < NREG; a++) begin
      beat_t b;
      b.areg = 5'(a);
      b.preg = map_tbl[a];
      b.data = (a == 0) ? 32'h0 : prf_mem[map_tbl[a]];
      b.last = (a == NREG - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic pulse_req();
    @(posedge clk); #1;
    dump_req = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
  endtask

  task automatic run_until_done(input int base, input int mode, input int limit, output bit ok);
    ok = 0;
    for (int c = 0; c < limit; c++) begin
      @(posedge clk); #1;
      if (done_cycs.size() > base) begin
        ok = 1;
        break;
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++;
    if (prf_rd_en !== 1'b0) begin bad++; $display("FAIL reset_prf_rd_en got=%b exp=0", prf_rd_en); end
    total++;
    if ({dump_busy, dump_done, dump_abort, out_last} !== 4'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000", {dump_busy, dump_done, dump_abort, out_last});
    end
    total++;
    if ({map_rd_addr, out_areg, out_preg, out_data} !== '0) begin
      bad++; $display("FAIL reset_data got=%h exp=0", {map_rd_addr, out_areg, out_preg, out_data});
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (dump_busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b exp=0", dump_busy); end
  endtask

  task automatic test_basic();
    int gb, db, rb, n;
    bit ok;
    randomize_state();
    map_tbl[0] = 7'd99;
    prf_mem[99] = 32'hDEAD_BEEF;
    map_tbl[5] = 7'd40;
    map_tbl[7] = 7'd12;
    prf_mem[40] = 32'h0000_1234;
    prf_mem[12] = 32'hFFFF_FFF6;
    build_expected();
    quiesced = 1'b1;
    out_ready = 1'b1;
    gb = got.size(); db = done_cycs.size(); rb = read_cycs.size();
    pulse_req();
    run_until_done(db, 0, 400, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_done_timeout got=0 exp=1"); end
    repeat (4) @(posedge clk);
    #1;
    n = got.size() - gb;
    total++;
    if (n !== NBEATS) begin bad++; $display("FAIL basic_count got=%0d exp=%0d", n, NBEATS); end
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      total++;
      if (got[gb + i] !== exp_q[i]) begin
        bad++; $display("FAIL basic_beat%0d got=%h exp=%h", i, got[gb + i], exp_q[i]);
      end
    end
    if (n > 7 - FIRST) begin
      total++;
      if ({got[gb + 5 - FIRST].areg, got[gb + 5 - FIRST].preg, got[gb + 5 - FIRST].data} !== {5'd5, 7'd40, 32'h1234}) begin
        bad++; $display("FAIL basic_x5 got=%h exp=%h", got[gb + 5 - FIRST], {5'd5, 7'd40, 32'h1234});
      end
      total++;
      if ($signed(got[gb + 7 - FIRST].data) !== -32'sd10) begin
        bad++; $display("FAIL basic_x7 got=%0d exp=-10", $signed(got[gb + 7 - FIRST].data));
      end
    end
    total++;
    if (done_cycs.size() - db !== 1) begin bad++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cycs.size() - db); end
    total++;
    if (read_cycs.size() - rb !== NBEATS) begin bad++; $display("FAIL basic_reads got=%0d exp=%0d", read_cycs.size() - rb, NBEATS); end
    if (ok && read_cycs.size() > rb) begin
      total++;
      if (done_cycs[db] - read_cycs[rb] !== 3 * NBEATS) begin
        bad++; $display("FAIL basic_cycles got=%0d exp=%0d", done_cycs[db] - read_cycs[rb], 3 * NBEATS);
      end
      total++;
      if (read_addrs[rb] !== FIRST) begin bad++; $display("FAIL basic_first_read got=%0d exp=%0d", read_addrs[rb], FIRST); end
    end
`ifdef ARCH_DUMP_SKIP_X0_EN
    for (int i = rb; i < read_addrs.size(); i++) begin
      total++;
      if (read_addrs[i] === 0) begin bad++; $display("FAIL skip_x0_read got=%0d exp=nonzero", read_addrs[i]); end
    end
`endif
  endtask

  task automatic test_backpressure(input int mode);
    int gb, db, rb, hv, n;
    bit ok;
    randomize_state();
    build_expected();
    quiesced = 1'b1;
    out_ready = 1'b0;
    gb = got.size(); db = done_cycs.size(); rb = read_cycs.size(); hv = hold_viol;
    pulse_req();
    repeat (5) @(posedge clk);
    #1;
    quiesced = 1'b0;
    dump_req = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
    run_until_done(db, mode, 800, ok);
    quiesced = 1'b1;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    total++;
    if (!ok) begin bad++; $display("FAIL bp%0d_done_timeout got=0 exp=1", mode); end
    n = got.size() - gb;
    total++;
    if (n !== NBEATS) begin bad++; $display("FAIL bp%0d_count got=%0d exp=%0d", mode, n, NBEATS); end
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      total++;
      if (got[gb + i] !== exp_q[i]) begin
        bad++; $display("FAIL bp%0d_beat%0d got=%h exp=%h", mode, i, got[gb + i], exp_q[i]);
      end
    end
    total++;
    if (hold_viol - hv !== 0) begin bad++; $display("FAIL bp%0d_hold got=%0d exp=0", mode, hold_viol - hv); end
    total++;
    if (read_cycs.size() - rb !== NBEATS || dump_busy !== 1'b0) begin
      bad++; $display("FAIL bp%0d_no_restart got=%0d/%b exp=%0d/0", mode, read_cycs.size() - rb, dump_busy, NBEATS);
    end
  endtask

  task automatic test_quiesce_wait();
    int gb, db, rb, qc, n;
    bit ok;
    randomize_state();
    build_expected();
    quiesced = 1'b0;
    out_ready = 1'b1;
    gb = got.size(); db = done_cycs.size(); rb = read_cycs.size();
    pulse_req();
    repeat (20) @(posedge clk);
    #1;
    total++;
    if (dump_busy !== 1'b1) begin bad++; $display("FAIL qwait_busy got=%b exp=1", dump_busy); end
    total++;
    if (read_cycs.size() - rb !== 0) begin bad++; $display("FAIL qwait_reads got=%0d exp=0", read_cycs.size() - rb); end
    quiesced = 1'b1;
    qc = cyc;
    run_until_done(db, 0, 400, ok);
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (!ok) begin bad++; $display("FAIL qwait_done_timeout got=0 exp=1"); end
    if (read_cycs.size() > rb) begin
      total++;
      if (read_cycs[rb] !== qc + 1) begin bad++; $display("FAIL qwait_first_map got=%0d exp=%0d", read_cycs[rb], qc + 1); end
    end
    n = got.size() - gb;
    total++;
    if (n !== NBEATS) begin bad++; $display("FAIL qwait_count got=%0d exp=%0d", n, NBEATS); end
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      total++;
      if (got[gb + i] !== exp_q[i]) begin
        bad++; $display("FAIL qwait_beat%0d got=%h exp=%h", i, got[gb + i], exp_q[i]);
      end
    end
  endtask

  task automatic test_flush_abort();
    int gb, db, ab, n;
    bit found, ok;
    randomize_state();
    build_expected();
    quiesced = 1'b1;
    out_ready = 1'b1;
    gb = got.size(); db = done_cycs.size(); ab = abort_cnt;
    pulse_req();
    found = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (out_valid && out_areg == 5'd10) begin
        out_ready = 1'b0;
        flush = 1'b1;
        found = 1;
        break;
      end
    end
    total++;
    if (!found) begin bad++; $display("FAIL flush_reach_x10 got=0 exp=1"); end
    @(posedge clk); #1;
    flush = 1'b0;
    total++;
    if ({out_valid, dump_abort, dump_busy} !== 3'b010) begin
      bad++; $display("FAIL flush_after got=%b exp=010", {out_valid, dump_abort, dump_busy});
    end
    @(posedge clk); #1;
    total++;
    if (dump_abort !== 1'b0) begin bad++; $display("FAIL flush_abort_width got=%b exp=0", dump_abort); end
    repeat (4) @(posedge clk);
    #1;
    n = got.size() - gb;
    total++;
    if (n !== 10 - FIRST) begin bad++; $display("FAIL flush_delivered got=%0d exp=%0d", n, 10 - FIRST); end
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      total++;
      if (got[gb + i] !== exp_q[i]) begin bad++; $display("FAIL flush_beat%0d got=%h exp=%h", i, got[gb + i], exp_q[i]); end
    end
    total++;
    if (done_cycs.size() - db !== 0 || abort_cnt - ab !== 1) begin
      bad++; $display("FAIL flush_pulses done=%0d abort=%0d exp done=0 abort=1", done_cycs.size() - db, abort_cnt - ab);
    end
    out_ready = 1'b1;
    gb = got.size(); db = done_cycs.size();
    pulse_req();
    run_until_done(db, 0, 400, ok);
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (!ok || got.size() - gb !== NBEATS) begin
      bad++; $display("FAIL flush_restart_count got=%0d exp=%0d", got.size() - gb, NBEATS);
    end
    if (got.size() > gb) begin
      total++;
      if (got[gb].areg !== 5'(FIRST)) begin bad++; $display("FAIL flush_restart_first got=%0d exp=%0d", got[gb].areg, FIRST); end
    end
  endtask

  task automatic test_req_flush_same();
    int ab, rb;
    ab = abort_cnt; rb = read_cycs.size();
    quiesced = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
    flush = 1'b0;
    total++;
    if (dump_busy !== 1'b0) begin bad++; $display("FAIL reqflush_busy got=%b exp=0", dump_busy); end
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (abort_cnt - ab !== 0 || read_cycs.size() - rb !== 0) begin
      bad++; $display("FAIL reqflush_quiet abort=%0d reads=%0d exp 0/0", abort_cnt - ab, read_cycs.size() - rb);
    end
  endtask

  task automatic test_reset_mid();
    int gb, rb;
    bit found;
    randomize_state();
    quiesced = 1'b1;
    out_ready = 1'b1;
    pulse_req();
    found = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (prf_rd_en && map_rd_addr == 5'd3) begin
        found = 1;
        break;
      end
    end
    total++;
    if (!found) begin bad++; $display("FAIL rstmid_reach_x3 got=0 exp=1"); end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    total++;
    if ({dump_busy, out_valid, prf_rd_en, dump_done, dump_abort, out_last} !== 6'b0) begin
      bad++; $display("FAIL rstmid_flags got=%b exp=000000", {dump_busy, out_valid, prf_rd_en, dump_done, dump_abort, out_last});
    end
    total++;
    if ({map_rd_addr, prf_rd_addr, out_areg, out_preg, out_data} !== '0) begin
      bad++; $display("FAIL rstmid_data got=%h exp=0", {map_rd_addr, prf_rd_addr, out_areg, out_preg, out_data});
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    gb = got.size(); rb = read_cycs.size();
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (dump_busy !== 1'b0 || read_cycs.size() - rb !== 0 || got.size() - gb !== 0) begin
      bad++; $display("FAIL rstmid_idle busy=%b reads=%0d beats=%0d exp 0/0/0", dump_busy, read_cycs.size() - rb, got.size() - gb);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure(1);
    test_backpressure(2);
    test_quiesce_wait();
    test_flush_abort();
    test_req_flush_same();
    test_reset_mid();
    test_basic();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arch_state_dump_unit.md
Name: arch_state_dump_unit

Overview:
- Hardware responder that reads the architectural register file out of the OoO core on request.
- For each architectural register it reads the rename map (areg -> preg), then reads the PRF, then streams {areg, preg, value} beats over a valid/ready port.
- Sits beside rename and the PRF in `processor`, and exposes committed state to a debug host or bench without hierarchical peeks.
- Dumps only while the core is quiesced (ROB empty); a flush aborts the dump.

Parameters:
- NUM_AREGS, 32, number of architectural registers walked.
- AREG_W, 5, architectural register index width.
- PREG_W, 7, physical register tag width (128-entry PRF).
- XLEN, 32, data width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- dump_req  in  1  single-cycle request to start a dump; ignored while busy.
- quiesced  in  1  high when ROB is empty and no in-flight writeback.
- flush  in  1  mispredict/flush pulse from the core.
- map_rd_addr  out  AREG_W  rename map read index.
- map_rd_preg  in  PREG_W  combinational map read data, same cycle as address.
- prf_rd_en  out  1  PRF read enable.
- prf_rd_addr  out  PREG_W  PRF read tag.
- prf_rd_data  in  XLEN  PRF read data, valid exactly 1 cycle after prf_rd_en.
- out_valid  out  1  beat valid.
- out_ready  in  1  consumer ready.
- out_areg  out  AREG_W  architectural index of the beat.
- out_preg  out  PREG_W  mapped physical tag.
- out_data  out  XLEN  register value.
- out_last  out  1  final beat of the dump.
- dump_busy  out  1  high in any state other than IDLE.
- dump_done  out  1  1-cycle pulse after the last beat handshakes.
- dump_abort  out  1  1-cycle pulse when a flush kills a dump.

Behaviour:
- Reset (async, reset=0): state IDLE; idx=0; all outputs 0, including out_valid, prf_rd_en, dump_done and dump_abort.
- FSM states: IDLE, WAIT_Q, MAP, PRF, SEND.
- IDLE: on dump_req go to WAIT_Q; idx = first index.
- WAIT_Q: hold until quiesced=1, then go to MAP. dump_req while busy is dropped.
- MAP:
  - Drive map_rd_addr = idx and capture map_rd_preg into preg_q.
  - Drive prf_rd_en=1 with prf_rd_addr = map_rd_preg in the same cycle.
  - Go to PRF.
- PRF:
  - Capture prf_rd_data into data_q and go to SEND.
  - Beat latency per register: 2 cycles from MAP to out_valid.
- SEND:
  - out_valid=1, driven from registers only (no combinational path from out_ready).
  - Outputs stay stable until out_valid && out_ready.
  - out_last=1 when idx == NUM_AREGS-1.
  - On handshake: if last, pulse dump_done and go to IDLE; else idx+1 and go to MAP.
- Minimum dump length: 3 cycles per register with out_ready held high; 32 regs = 96 cycles after quiesced.
- quiesced dropping mid-dump (not via flush) is a protocol error:
  - The unit keeps going.
  - The verifier checks that the core never retires during a dump when the core is correctly gated.
- flush=1 in WAIT_Q/MAP/PRF/SEND:
  - Drop out_valid next cycle; no further beats.
  - Pulse dump_abort; go to IDLE.
  - A beat handshaking in the flush cycle counts as delivered.
- flush in IDLE: no effect.
- dump_req and flush in the same cycle in IDLE: flush wins; stay IDLE, no abort pulse.
- idx wraps only via reset to the first index at each dump start; it never exceeds NUM_AREGS-1.
- x0: the map is read normally, but out_data is forced to 0 regardless of PRF contents.
- dump_busy is combinational from state != IDLE.

Optional Feature:
- Macro: ARCH_DUMP_SKIP_X0_EN.
- Defined:
  - Dump starts at idx=1 and emits NUM_AREGS-1 beats (31).
  - x0 is never read from the map or PRF.
  - out_last is still asserted on idx=31.
- Undefined: 32 beats, with x0 emitted as data 0.

Decomposition:
- Shared package arch_dump_pkg holds:
  - dump_state_t enum {IDLE, WAIT_Q, MAP, PRF, SEND};
  - AREG_W, PREG_W, XLEN localparams;
  - a packed struct dump_beat_t {areg, preg, data}.
- One sub-module is natural: dump_out_stage.
  - A single-entry output register holding dump_beat_t + last, with valid/ready hold semantics.
  - Reused for any future debug stream.

Test Plan:
- Basic dump: PRF preloaded so x5 -> p40 = 0x0000_1234, x7 -> p12 = 0xFFFF_FFF6; quiesced=1, dump_req pulse, out_ready=1 -> 32 beats in order areg 0..31; beat 5 = {5, 40, 0x1234}; beat 7 data = -10; out_last only on beat 31; dump_done 1 cycle after; 96 beats-cycles total.
- Backpressure: out_ready toggles 1/0 every cycle -> every beat held stable while out_ready=0; no beat lost or duplicated; 32 beats delivered.
- Quiesce wait: dump_req with quiesced=0 for 20 cycles -> no map/PRF reads, dump_busy=1; first MAP exactly 1 cycle after quiesced rises.
- Flush abort: flush asserted during SEND of areg 10 with out_ready=0 -> out_valid=0 next cycle, dump_abort pulse, no dump_done, state IDLE; a new dump_req then restarts at areg 0.
- Reset mid-dump: reset low during PRF of areg 3 -> all outputs 0 immediately (async); after release, idle until a new dump_req.
- ARCH_DUMP_SKIP_X0_EN defined -> first beat areg=1, 31 beats, map_rd_addr never 0.
